// File: rtl/jtag_bus_master_pkg.sv
// Shared definitions for the debug bus master: FSM encoding, default widths,
// timeout counter sizing and the completion error code.
package jtag_bus_master_pkg;

    localparam int unsigned ADDR_W_DEFAULT  = 32;
    localparam int unsigned DATA_W_DEFAULT  = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 256;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StDone
    } state_e;

    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_FAIL = 1'b1;

    function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int unsigned TIMEOUT_W_DEFAULT = timeout_cnt_w(TIMEOUT_DEFAULT);

endpackage

// File: rtl/jtag_bus_timeout.sv
// Wait-for-ack watchdog: counts enabled cycles and flags the last allowed one.
module jtag_bus_timeout
    import jtag_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = timeout_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q, count_d;

    // Expiry is combinational so the FSM can abort in the same cycle.
    assign expired = enable && (count_q == Last);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/jtag_bus_master.sv
// Converts four-phase debug memory requests into single-beat system bus
// transactions, holding the core pipeline while the bus is borrowed.
module jtag_bus_master
    import jtag_bus_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W         = DATA_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              hold_o
);

    state_e            state_q, state_d;
    logic              req_seen_q, req_seen_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tmo_clear, tmo_enable, tmo_expired;

    jtag_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        req_seen_d = req_seen_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tmo_clear  = 1'b0;
        tmo_enable = 1'b0;

        unique case (state_q)
            StIdle: begin
                // req_seen forces a low phase between accesses.
                if (dbg_req_i && !req_seen_q) begin
                    req_seen_d = 1'b1;
                    we_d       = dbg_we_i;
                    addr_d     = dbg_addr_i;
                    wdata_d    = dbg_wdata_i;
                    if (dbg_addr_i[1:0] != 2'b00) begin
                        rdata_d = '0;
                        err_d   = ERR_FAIL;
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                tmo_clear = 1'b1;
                state_d   = StWaitAck;
            end
            StWaitAck: begin
                tmo_enable = 1'b1;
                // Ack takes priority over a coincident timeout.
                if (bus_ack_i) begin
                    rdata_d = we_q ? '0 : bus_rdata_i;
                    err_d   = ERR_NONE;
                    state_d = StDone;
                end else if (tmo_expired) begin
                    rdata_d = '0;
                    err_d   = ERR_FAIL;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!dbg_req_i) begin
                    req_seen_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_seen_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_seen_q <= req_seen_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign dbg_ack_o   = (state_q == StDone);
    assign dbg_rdata_o = rdata_q;
    assign dbg_err_o   = err_q;
    assign bus_req_o   = (state_q == StWaitAck);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign hold_o      = (state_q == StIssue) || (state_q == StWaitAck);

endmodule

// File: tb/tb_jtag_bus_master.sv
// Randomized self-checking bench for jtag_bus_master against a cycle-count
// reference model of the debug access protocol.
module tb_jtag_bus_master;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_ack, dbg_err;
    logic [31:0] dbg_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack, hold;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jtag_bus_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dbg_req_i  (dbg_req),
        .dbg_we_i   (dbg_we),
        .dbg_addr_i (dbg_addr),
        .dbg_wdata_i(dbg_wdata),
        .dbg_ack_o  (dbg_ack),
        .dbg_rdata_o(dbg_rdata),
        .dbg_err_o  (dbg_err),
        .bus_req_o  (bus_req),
        .bus_we_o   (bus_we),
        .bus_addr_o (bus_addr),
        .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata),
        .bus_ack_i  (bus_ack),
        .hold_o     (hold)
    );

    // delay: WAIT_ACK cycles before the bus acks (0 = first), <0 = never.
    // extra_hold: cycles dbg_req stays high after completion.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int delay, input int extra_hold,
                              input string tag);
        bit          misal;
        int          bc;
        int          done_c;
        logic        exp_err, e_req, e_hold, e_ack;
        logic [31:0] exp_rd;

        misal = (addr[1:0] != 2'b00);
        if (misal) begin
            bc = 0; done_c = 1; exp_err = 1'b1; exp_rd = '0;
        end else if (delay >= 0 && delay < int'(T)) begin
            bc = delay + 1; done_c = 2 + bc; exp_err = 1'b0; exp_rd = we ? 32'h0 : rdata;
        end else begin
            bc = int'(T); done_c = 2 + bc; exp_err = 1'b1; exp_rd = '0;
        end

        @(negedge clk);
        dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (c == 1) begin
                dbg_we = ~we; dbg_addr = $urandom; dbg_wdata = $urandom;
            end
            e_req  = !misal && c >= 2 && c < 2 + bc;
            e_hold = !misal && c < 2 + bc;
            e_ack  = (c == done_c);
            n_cmp++;
            if (bus_req !== e_req) begin
                n_bad++; $display("FAIL %s bus_req c%0d: got %b want %b", tag, c, bus_req, e_req);
            end
            n_cmp++;
            if (hold !== e_hold) begin
                n_bad++; $display("FAIL %s hold c%0d: got %b want %b", tag, c, hold, e_hold);
            end
            n_cmp++;
            if (dbg_ack !== e_ack) begin
                n_bad++; $display("FAIL %s dbg_ack c%0d: got %b want %b", tag, c, dbg_ack, e_ack);
            end
            if (e_req) begin
                n_cmp++;
                if (bus_we !== we || bus_addr !== addr || bus_wdata !== wdata) begin
                    n_bad++;
                    $display("FAIL %s bus_fields c%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                             tag, c, bus_we, bus_addr, bus_wdata, we, addr, wdata);
                end
            end
            if (e_ack) begin
                n_cmp++;
                if (dbg_rdata !== exp_rd || dbg_err !== exp_err) begin
                    n_bad++;
                    $display("FAIL %s result: got rd=%h err=%b want rd=%h err=%b",
                             tag, dbg_rdata, dbg_err, exp_rd, exp_err);
                end
            end
            if (!misal && delay >= 0 && c == 2 + delay) begin
                bus_ack = 1'b1;
                bus_rdata = rdata;
            end
        end

        for (int k = 0; k < extra_hold; k++) begin
            @(negedge clk);
            bus_ack = 1'($urandom_range(0, 1));
            n_cmp++;
            if (dbg_ack !== 1'b1 || bus_req !== 1'b0 || hold !== 1'b0 ||
                dbg_rdata !== exp_rd || dbg_err !== exp_err) begin
                n_bad++;
                $display("FAIL %s held k%0d: got ack=%b req=%b hold=%b rd=%h err=%b want 1 0 0 %h %b",
                         tag, k, dbg_ack, bus_req, hold, dbg_rdata, dbg_err, exp_rd, exp_err);
            end
        end
        dbg_req = 1'b0;
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++;
        if (dbg_ack !== 1'b0 || bus_req !== 1'b0 || hold !== 1'b0) begin
            n_bad++;
            $display("FAIL %s release: got ack=%b req=%b hold=%b want 0 0 0",
                     tag, dbg_ack, bus_req, hold);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dbg_ack, dbg_err, bus_req, bus_we, hold} !== 5'b0 || dbg_rdata !== '0 ||
            bus_addr !== '0 || bus_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got ack=%b err=%b req=%b we=%b hold=%b rd=%h a=%h d=%h want all 0",
                     dbg_ack, dbg_err, bus_req, bus_we, hold, dbg_rdata, bus_addr, bus_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        run_access(1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, "read");
    endtask

    task automatic test_write();
        run_access(1'b1, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 5, 0, "write");
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 32'h0000_0002, 32'h0, 32'h5555_5555, 0, 0, "misaligned");
    endtask

    task automatic test_timeout();
        run_access(1'b0, 32'h0000_0100, 32'h0, 32'h0, -1, 0, "timeout");
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++;
        if (dbg_ack !== 1'b0 || bus_req !== 1'b0 || hold !== 1'b0) begin
            n_bad++;
            $display("FAIL late_ack: got ack=%b req=%b hold=%b want 0 0 0", dbg_ack, bus_req, hold);
        end
        run_access(1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_CAFE, int'(T) - 1, 0, "ack_at_timeout");
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_0001, 1, 10, "handshake_1");
        run_access(1'b1, 32'h0000_0044, 32'h7777_0002, 32'h0, 2, 0, "handshake_2");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dbg_we = 1'b0; dbg_addr = 32'h0000_0020; dbg_req = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus_req !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_pre: got bus_req=%b want 1", bus_req);
        end
        rst_n = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (bus_req !== 1'b0 || hold !== 1'b0 || dbg_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_post: got req=%b hold=%b ack=%b want 0 0 0", bus_req, hold, dbg_ack);
        end
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        @(negedge clk);
        bus_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (dbg_ack !== 1'b0 || bus_req !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid_ack k%0d: got ack=%b req=%b want 0 0", k, dbg_ack, bus_req);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          delay;
        for (int i = 0; i < 40; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            delay = int'($urandom_range(0, T + 2)) - 1;
            run_access(1'($urandom_range(0, 1)), addr, $urandom, $urandom, delay,
                       int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_bus_master.md
Name: jtag_bus_master

Overview:
- Downstream consumer of the debug module's memory-access outputs (mem_we/mem_addr/mem_wdata/op_req).
- Turns each debug memory request into one single-beat transaction on the core's system bus.
- Returns read data and completion status over a four-phase handshake.
- Asserts a pipeline hold toward the core while a debug access owns the bus.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- TIMEOUT_CYCLES, 256, maximum cycles spent waiting for bus_ack_i before aborting with an error; must be >= 2.

Ports:
- clk  in  1  single clock; all inputs are already in this domain.
- rst_n  in  1  synchronous, active-low reset.
- dbg_req_i  in  1  debug request level; four-phase with dbg_ack_o.
- dbg_we_i  in  1  1 = write, 0 = read; sampled at capture.
- dbg_addr_i  in  ADDR_W  byte address; sampled at capture.
- dbg_wdata_i  in  DATA_W  write data; sampled at capture.
- dbg_ack_o  out  1  completion; held until dbg_req_i falls.
- dbg_rdata_o  out  DATA_W  read result; valid while dbg_ack_o = 1.
- dbg_err_o  out  1  access failed (misaligned or timeout); valid while dbg_ack_o = 1.
- bus_req_o  out  1  bus request; held until bus_ack_i.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_rdata_i  in  DATA_W  bus read data; valid in the bus_ack_i cycle.
- bus_ack_i  in  1  one-cycle completion from the bus.
- hold_o  out  1  stall request to the core pipeline.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0; captured registers 0; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT_ACK, DONE.
- IDLE:
  - On dbg_req_i = 1 with the internal req_seen flag = 0: capture we/addr/wdata and set req_seen.
  - If addr[1:0] != 0: go to DONE with err = 1, rdata = 0, no bus activity.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert hold_o; clear the timeout counter.
  - Go to WAIT_ACK. The hold cycle lets the core drain before bus_req_o rises.
- WAIT_ACK:
  - Drive bus_req_o = 1 and bus_we/addr/wdata from the captured values; hold_o = 1; counter increments each cycle.
  - On bus_ack_i = 1: latch bus_rdata_i into dbg_rdata_o (reads only; writes return 0), err = 0, drop bus_req_o the next cycle, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES - 1 without an ack: drop bus_req_o, err = 1, rdata = 0, go to DONE.
  - If ack and timeout coincide, the ack wins.
- DONE:
  - dbg_ack_o = 1 and hold_o = 0; dbg_rdata_o and dbg_err_o stable.
  - When dbg_req_i = 0: dbg_ack_o falls the next cycle, req_seen clears, return to IDLE.
- Latency, aligned access with zero-wait ack: dbg_req_i high at cycle 0 -> ISSUE at 1 -> bus_req_o high at 2 -> ack at 2 -> dbg_ack_o high at 3.
- dbg_req_i dropping before DONE (protocol violation): the access still completes; DONE then sees req low and returns to IDLE after one dbg_ack_o cycle.
- dbg_req_i held high after ack: no re-issue. A new access requires a low phase first (enforced by req_seen).
- Changes to dbg_* data inputs after capture are ignored.
- Reset mid-operation: bus_req_o and hold_o drop in the reset cycle; no ack is generated; a later bus_ack_i is ignored in IDLE.
- bus_ack_i outside WAIT_ACK is ignored.

Decomposition:
- Shared debug package holds: FSM state encoding, ADDR_W/DATA_W defaults, the timeout width constant ($clog2(TIMEOUT_CYCLES)), and the error-code bit.
- The timeout counter is the one natural sub-module: jtag_bus_timeout, with inputs clear and enable and a one-cycle expired output.
- The rest stays flat.

Test Plan:
- Read: dbg addr 0x1000_0004, we = 0; bus acks on the 1st WAIT_ACK cycle with 0xDEAD_BEEF -> bus_addr_o = 0x1000_0004, bus_we_o = 0; dbg_ack_o at cycle 3; dbg_rdata_o = 0xDEAD_BEEF; err = 0; hold_o high on cycles 1-2 only.
- Write: addr 0x0000_0010, wdata 0x1234_5678; ack after 5 wait cycles -> bus_wdata_o = 0x1234_5678 and bus_we_o = 1 throughout WAIT_ACK; dbg_rdata_o = 0; err = 0.
- Misaligned: addr 0x0000_0002 -> bus_req_o never asserts; dbg_ack_o at cycle 1 with err = 1.
- Timeout: TIMEOUT_CYCLES = 8, no ack -> bus_req_o high exactly 8 cycles then drops; dbg_ack_o with err = 1; a late bus_ack_i after that is ignored.
- Handshake: keep dbg_req_i high for 10 cycles after ack -> only one bus transaction. Then drop dbg_req_i and raise it again -> a second transaction.
- Reset mid-WAIT_ACK: rst_n low for 1 cycle -> bus_req_o, hold_o and dbg_ack_o are 0 the next cycle; a following ack produces no dbg_ack_o.
